// File: rtl/serial_tx_fifo.sv
// UART transmitter (8N1 / 8N2, LSB first) fed by a byte FIFO.
// TX and busy decode straight from the state register, so reset returns the line high at once.
module serial_tx_fifo #(
  parameter int CLK_IN    = 0,
  parameter int BAUD      = 0,
  parameter int DEPTH     = 512,
  parameter int STOP_BITS = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic [7:0]               din,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   data_count,
  output logic                     overflow,
  output logic                     busy,
  output logic                     TX
);

  localparam int AW        = $clog2(DEPTH);
  // A zero BAUD must not break elaboration; a real instance always sets both rates.
  localparam int BAUD_SAFE = (BAUD > 0) ? BAUD : 1;
  localparam int DIV_RAW   = CLK_IN / BAUD_SAFE;
  localparam int BAUD_DIV  = (DIV_RAW < 2) ? 2 : DIV_RAW;
  localparam int STOP_LEN  = ((STOP_BITS == 2) ? 2 : 1) * BAUD_DIV;
  localparam int CW        = $clog2(STOP_LEN);

  localparam logic [CW-1:0] BIT_LAST  = CW'(BAUD_DIV - 1);
  localparam logic [CW-1:0] STOP_LAST = CW'(STOP_LEN - 1);
  localparam logic [AW:0]   FULL_CNT  = (AW + 1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t         state, state_next;
  logic [CW-1:0]  bit_cnt, bit_cnt_next;
  logic [2:0]     bit_idx, bit_idx_next;
  logic [7:0]     shift_reg, shift_next;
  logic           tx_next;

  logic [7:0]     mem [DEPTH];
  logic [AW-1:0]  wr_ptr, rd_ptr;
  logic [AW:0]    count_next;
  logic           push, pop;

  // A write while full is dropped; full wins even when a pop happens that cycle.
  assign push = wr_en && !full;

  always_comb begin
    count_next = data_count;
    case ({push, pop})
      2'b10:   count_next = data_count + (AW + 1)'(1);
      2'b01:   count_next = data_count - (AW + 1)'(1);
      default: count_next = data_count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      data_count <= '0;
      full       <= 1'b0;
      empty      <= 1'b1;
      overflow   <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      data_count <= count_next;
      full       <= (count_next == FULL_CNT);
      empty      <= (count_next == '0);
      overflow   <= wr_en && full;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      bit_idx   <= '0;
      shift_reg <= '0;
    end else begin
      state     <= state_next;
      bit_cnt   <= bit_cnt_next;
      bit_idx   <= bit_idx_next;
      shift_reg <= shift_next;
    end
  end

  // pop is only raised against the registered empty flag, so a byte written
  // into an empty FIFO is taken on the following cycle.
  always_comb begin
    state_next   = state;
    bit_cnt_next = bit_cnt + CW'(1);
    bit_idx_next = bit_idx;
    shift_next   = shift_reg;
    pop          = 1'b0;
    tx_next      = 1'b1;
    case (state)
      IDLE: begin
        bit_cnt_next = '0;
        if (!empty) begin
          pop        = 1'b1;
          shift_next = mem[rd_ptr];
          state_next = START;
        end
      end
      START: begin
        tx_next = 1'b0;
        if (bit_cnt == BIT_LAST) begin
          bit_cnt_next = '0;
          bit_idx_next = '0;
          state_next   = DATA;
        end
      end
      DATA: begin
        tx_next = shift_reg[0];
        if (bit_cnt == BIT_LAST) begin
          bit_cnt_next = '0;
          shift_next   = {1'b0, shift_reg[7:1]};
          bit_idx_next = bit_idx + 3'd1;
          if (bit_idx == 3'd7) state_next = STOP;
        end
      end
      STOP: begin
        tx_next = 1'b1;
        if (bit_cnt == STOP_LAST) begin
          bit_cnt_next = '0;
          if (!empty) begin
            pop        = 1'b1;
            shift_next = mem[rd_ptr];
            state_next = START;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: begin
        bit_cnt_next = '0;
        state_next   = IDLE;
      end
    endcase
  end

  assign TX   = tx_next;
  assign busy = (state != IDLE);

endmodule

// File: tb/tb_serial_tx_fifo.sv
// Directed bench for serial_tx_fifo: table of bytes with hand-computed line patterns,
// multi-cycle corner sequences, and a STOP_BITS=2 loopback through a bench-side receiver.
module tb_serial_tx_fifo;

  logic       clk;
  logic       rst_n;
  logic       wr_en, wr2;
  logic [7:0] din, din2;
  logic       full, empty, overflow, busy, tx;
  logic [2:0] data_count;
  logic       full2, empty2, overflow2, busy2, tx2;
  logic [2:0] data_count2;

  int n_vec = 0;
  int n_err = 0;
  int rx_cnt = 0;
  logic [7:0] exp_q[$];

  serial_tx_fifo #(.CLK_IN(100_000_000), .BAUD(1_000_000), .DEPTH(4), .STOP_BITS(1)) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .din(din), .full(full), .empty(empty),
    .data_count(data_count), .overflow(overflow), .busy(busy), .TX(tx)
  );

  serial_tx_fifo #(.CLK_IN(100_000_000), .BAUD(25_000_000), .DEPTH(4), .STOP_BITS(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .wr_en(wr2), .din(din2), .full(full2), .empty(empty2),
    .data_count(data_count2), .overflow(overflow2), .busy(busy2), .TX(tx2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct packed {
    logic [7:0] data;
    logic [9:0] line;  // line bit i = i-th bit on the wire: start, d0..d7, stop
  } vec_t;

  vec_t tbl [13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Called at the negedge of frame cycle off; returns at the negedge of cycle last.
  task automatic check_frame(input logic [9:0] line, input int off, input int last);
    for (int c = off; c < last; c++) begin
      if ((c % 100) == 0 || (c % 100) == 99) begin
        chk($sformatf("tx_bit%0d_c%0d", c / 100, c), tx, line[c / 100]);
        chk("busy_in_frame", busy, 1'b1);
      end
      @(negedge clk);
    end
  endtask

  // Called at a negedge while idle: one write, latency check, whole frame, then idle.
  task automatic single_frame(input int idx);
    wr_en = 1'b1;
    din   = tbl[idx].data;
    @(posedge clk);
    #1 wr_en = 1'b0;
    @(negedge clk);
    chk("queued_count", data_count, 3'd1);
    chk("queued_empty", empty, 1'b0);
    chk("tx_before_start", tx, 1'b1);
    chk("busy_before_start", busy, 1'b0);
    @(negedge clk);
    chk("popped_count", data_count, 3'd0);
    check_frame(tbl[idx].line, 0, 1000);
    chk("busy_after_frame", busy, 1'b0);
    chk("tx_after_frame", tx, 1'b1);
    chk("empty_after_frame", empty, 1'b1);
  endtask

  // Bench-side 8N2 receiver on dut2, four clocks per bit, sampling mid-bit.
  initial begin
    logic [7:0] rx;
    forever begin
      @(negedge clk);
      if (rst_n && tx2 === 1'b0) begin
        repeat (2) @(negedge clk);
        chk("rx_start_bit", tx2, 1'b0);
        for (int i = 0; i < 8; i++) begin
          repeat (4) @(negedge clk);
          rx[i] = tx2;
        end
        repeat (4) @(negedge clk);
        chk("rx_stop1", tx2, 1'b1);
        repeat (4) @(negedge clk);
        chk("rx_stop2", tx2, 1'b1);
        if (exp_q.size() == 0) begin
          chk("rx_unexpected_byte", 32'd1, 32'd0);
        end else begin
          chk($sformatf("rx_byte%0d", rx_cnt), rx, exp_q.pop_front());
        end
        rx_cnt++;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int budget;
    tbl[0]  = '{8'hA5, 10'h34A};
    tbl[1]  = '{8'h00, 10'h200};
    tbl[2]  = '{8'hFF, 10'h3FE};
    tbl[3]  = '{8'h3C, 10'h278};
    tbl[4]  = '{8'h10, 10'h220};
    tbl[5]  = '{8'h11, 10'h222};
    tbl[6]  = '{8'h12, 10'h224};
    tbl[7]  = '{8'h13, 10'h226};
    tbl[8]  = '{8'h14, 10'h228};
    tbl[9]  = '{8'h81, 10'h302};
    tbl[10] = '{8'h5A, 10'h2B4};
    tbl[11] = '{8'hC3, 10'h386};
    tbl[12] = '{8'h0F, 10'h21E};

    rst_n = 1'b0; wr_en = 1'b0; din = '0; wr2 = 1'b0; din2 = '0;
    repeat (3) @(negedge clk);
    chk("rst_tx", tx, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_empty", empty, 1'b1);
    chk("rst_full", full, 1'b0);
    chk("rst_count", data_count, 3'd0);
    chk("rst_overflow", overflow, 1'b0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 4; i++) single_frame(i);

    // Back-to-back 0x00 then 0xFF: no idle gap between the frames.
    wr_en = 1'b1; din = 8'h00;
    @(posedge clk);
    @(negedge clk);
    chk("b2b_count_after_first", data_count, 3'd1);
    din = 8'hFF;
    @(posedge clk);
    @(negedge clk);
    wr_en = 1'b0;
    chk("b2b_count_write_and_pop", data_count, 3'd1);
    check_frame(tbl[1].line, 0, 1000);
    chk("b2b_count_second_pop", data_count, 3'd0);
    check_frame(tbl[2].line, 0, 1000);
    chk("b2b_busy_end", busy, 1'b0);

    // Six consecutive writes into a depth-4 FIFO: 0x15 is dropped.
    wr_en = 1'b1;
    for (int i = 0; i < 6; i++) begin
      din = 8'h10 + 8'(i);
      if (i == 5) begin
        chk("ovf_full", full, 1'b1);
        chk("ovf_count_full", data_count, 3'd4);
        chk("ovf_no_pulse_yet", overflow, 1'b0);
      end
      @(posedge clk);
      @(negedge clk);
    end
    wr_en = 1'b0;
    chk("ovf_pulse", overflow, 1'b1);
    chk("ovf_count_kept", data_count, 3'd4);
    @(negedge clk);
    chk("ovf_pulse_one_cycle", overflow, 1'b0);
    check_frame(tbl[4].line, 5, 1000);
    chk("ovf_count_after_pop", data_count, 3'd3);
    chk("ovf_not_full", full, 1'b0);
    for (int i = 5; i <= 8; i++) check_frame(tbl[i].line, 0, 1000);
    chk("ovf_busy_end", busy, 1'b0);
    chk("ovf_empty_end", empty, 1'b1);

    // Write on the STOP cycle that pops, with two bytes queued.
    wr_en = 1'b1; din = 8'h81;
    @(posedge clk);
    @(negedge clk);
    din = 8'h5A;
    @(posedge clk);
    @(negedge clk);
    din = 8'hC3;
    @(posedge clk);
    @(negedge clk);
    wr_en = 1'b0;
    chk("sim_count_before", data_count, 3'd2);
    check_frame(tbl[9].line, 1, 999);
    chk("sim_last_stop_tx", tx, 1'b1);
    chk("sim_last_stop_count", data_count, 3'd2);
    wr_en = 1'b1; din = 8'h0F;
    @(negedge clk);
    wr_en = 1'b0;
    chk("sim_count_unchanged", data_count, 3'd2);
    chk("sim_no_gap_tx", tx, 1'b0);
    check_frame(tbl[10].line, 0, 1000);
    check_frame(tbl[11].line, 0, 1000);
    check_frame(tbl[12].line, 0, 1000);
    chk("sim_busy_end", busy, 1'b0);

    // Reset during data bit 3 of 0x00 with 0xFF still queued.
    wr_en = 1'b1; din = 8'h00;
    @(posedge clk);
    @(negedge clk);
    din = 8'hFF;
    @(posedge clk);
    @(negedge clk);
    wr_en = 1'b0;
    check_frame(tbl[1].line, 0, 450);
    chk("mid_reset_tx_low", tx, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_tx", tx, 1'b1);
    chk("async_rst_busy", busy, 1'b0);
    chk("async_rst_empty", empty, 1'b1);
    chk("async_rst_count", data_count, 3'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("post_rst_idle_tx", tx, 1'b1);
    single_frame(3);

    // Loopback of 0x00..0xFF through the STOP_BITS=2 instance.
    for (int i = 0; i < 256; i++) begin
      budget = 0;
      while (full2 && budget < 200) begin
        @(negedge clk);
        budget++;
      end
      if (budget >= 200) chk("lb_full_timeout", 32'd1, 32'd0);
      wr2 = 1'b1; din2 = 8'(i);
      exp_q.push_back(8'(i));
      @(posedge clk);
      #1 wr2 = 1'b0;
      @(negedge clk);
    end
    budget = 0;
    while (rx_cnt < 256 && budget < 20000) begin
      @(negedge clk);
      budget++;
    end
    chk("lb_rx_count", rx_cnt, 256);
    chk("lb_queue_drained", exp_q.size(), 0);
    chk("lb_overflow", overflow2, 1'b0);
    repeat (50) @(negedge clk);
    chk("lb_idle_busy", busy2, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
